// File: rtl/delay_pulse_multi_if.sv
// Serial register bus between the command decoder and delay_pulse_multi.
// The decoder is the master; the delay block is the slave and returns read data.
interface delay_pulse_multi_if;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;

    modport master (
        output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        input  reg_data_out
    );

    modport slave (
        input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        output reg_data_out
    );
endinterface

// File: rtl/delay_pulse_multi.sv
// Multi-channel trigger delay / pulse generator.
// Each channel synchronises its trigger input, detects the selected edge,
// waits DELAY clocks and then drives a WIDTH-clock pulse. A bank of
// channel-indexed registers (selected by CH_SEL) is reached over the serial
// register bus.
module delay_pulse_multi #(
    parameter int         NUM_CH      = 4,
    parameter int         CNT_WIDTH   = 32,
    parameter logic [7:0] CMD_BASE    = 8'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              timerclk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] trigger_in,
    delay_pulse_multi_if.slave reg_if,
    output logic [NUM_CH-1:0] trigger,
    output logic              trigger_any
);
    localparam int                   NB       = CNT_WIDTH / 8;
    localparam int                   BW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int                   CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0]           NUM_CH_B = 8'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARMED, ST_DELAY, ST_PULSE, ST_DONE
    } state_t;

    // Register bank (one entry per channel) and shared channel select
    logic [7:0]           r_ch_sel;
    logic [CNT_WIDTH-1:0] r_delay  [NUM_CH];
    logic [CNT_WIDTH-1:0] r_width  [NUM_CH];
    logic [2:0]           r_ctrl   [NUM_CH];
    logic [7:0]           r_missed [NUM_CH];
    logic [2:0]           w_status [NUM_CH];

    logic [NUM_CH-1:0] w_ch_hit;
    logic [NUM_CH-1:0] w_miss_inc;
    logic [NUM_CH-1:0] w_pulse;
    logic [NUM_CH-1:0] r_trigger;
    logic              r_trigger_any;

    // Bus decode
    logic            w_cmd_chsel, w_cmd_delay, w_cmd_width, w_cmd_ctrl, w_cmd_status;
    logic            w_bc0, w_bc1, w_bc_cnt, w_ch_valid;
    logic [BW-1:0]   w_byte_idx;
    logic [CHW-1:0]  w_ch;
    logic            w_wr_chsel, w_wr_delay, w_wr_width, w_wr_ctrl, w_wr_status;

    assign w_cmd_chsel  = (reg_if.reg_cmd == CMD_BASE);
    assign w_cmd_delay  = (reg_if.reg_cmd == CMD_BASE + 8'd1);
    assign w_cmd_width  = (reg_if.reg_cmd == CMD_BASE + 8'd2);
    assign w_cmd_ctrl   = (reg_if.reg_cmd == CMD_BASE + 8'd3);
    assign w_cmd_status = (reg_if.reg_cmd == CMD_BASE + 8'd4);
    assign w_bc0        = (reg_if.reg_bytecount == 16'd0);
    assign w_bc1        = (reg_if.reg_bytecount == 16'd1);
    assign w_bc_cnt     = (reg_if.reg_bytecount < 16'(NB));
    assign w_byte_idx   = reg_if.reg_bytecount[BW-1:0];
    assign w_ch_valid   = (r_ch_sel < NUM_CH_B);
    assign w_ch         = r_ch_sel[CHW-1:0];

    assign w_wr_chsel  = reg_if.reg_write && w_cmd_chsel && w_bc0;
    assign w_wr_delay  = reg_if.reg_write && w_cmd_delay && w_bc_cnt && w_ch_valid;
    assign w_wr_width  = reg_if.reg_write && w_cmd_width && w_bc_cnt && w_ch_valid;
    assign w_wr_ctrl   = reg_if.reg_write && w_cmd_ctrl && w_bc0 && w_ch_valid;
    assign w_wr_status = reg_if.reg_write && w_cmd_status && w_ch_valid;

    // Register writes, plus the saturating missed-trigger counters
    always_ff @(posedge timerclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch_sel <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_delay[i]  <= '0;
                r_width[i]  <= CNT_ONE;
                r_ctrl[i]   <= '0;
                r_missed[i] <= '0;
            end
        end else begin
            if (w_wr_chsel)
                r_ch_sel <= reg_if.reg_data_in;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_delay && w_ch_hit[i])
                    r_delay[i][{w_byte_idx, 3'b000} +: 8] <= reg_if.reg_data_in;
                if (w_wr_width && w_ch_hit[i])
                    r_width[i][{w_byte_idx, 3'b000} +: 8] <= reg_if.reg_data_in;
                if (w_wr_ctrl && w_ch_hit[i])
                    r_ctrl[i] <= reg_if.reg_data_in[2:0];
                if (w_wr_status && w_ch_hit[i])
                    r_missed[i] <= '0;
                else if (w_miss_inc[i] && (r_missed[i] != 8'hFF))
                    r_missed[i] <= r_missed[i] + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;
        logic                   w_last, w_hw_edge, w_sw, w_edge;
        logic                   w_disable, w_rearm, w_load;
        state_t                 r_state, w_state_next;
        logic [CNT_WIDTH-1:0]   r_dcnt, r_wcnt, r_dwork, r_wwork;

        assign w_ch_hit[gi] = (r_ch_sel == 8'(gi));
        assign w_last       = r_sync[SYNC_STAGES-1];
        assign w_hw_edge    = r_ctrl[gi][1] ? (r_prev & ~w_last) : (~r_prev & w_last);
        assign w_sw         = w_wr_ctrl && w_ch_hit[gi] && reg_if.reg_data_in[3];
        assign w_edge       = w_hw_edge | w_sw;
        assign w_disable    = w_wr_ctrl && w_ch_hit[gi] && !reg_if.reg_data_in[0];
        assign w_rearm      = w_wr_ctrl && w_ch_hit[gi] && reg_if.reg_data_in[0];
        assign w_pulse[gi]  = (r_state == ST_PULSE) && !w_disable;
        assign w_status[gi] = {r_state == ST_DONE,
                               (r_state == ST_DELAY) || (r_state == ST_PULSE),
                               r_state == ST_ARMED};

        // Input synchroniser and one-cycle-delayed copy for edge detection
        always_ff @(posedge timerclk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync <= '0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_in[gi]};
                r_prev <= w_last;
            end
        end

        // Channel state register
        always_ff @(posedge timerclk or negedge reset_n) begin
            if (!reset_n)
                r_state <= ST_IDLE;
            else
                r_state <= w_state_next;
        end

        // Next-state logic; edges seen while busy are reported as missed
        always_comb begin
            w_state_next   = r_state;
            w_load         = 1'b0;
            w_miss_inc[gi] = 1'b0;
            if (w_disable) begin
                w_state_next = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:
                        if (r_ctrl[gi][0]) w_state_next = ST_ARMED;
                    ST_ARMED:
                        if (w_edge) begin
                            w_load       = 1'b1;
                            w_state_next = (r_delay[gi] == '0) ? ST_PULSE : ST_DELAY;
                        end
                    ST_DELAY: begin
                        w_miss_inc[gi] = w_edge;
                        if (r_dcnt == r_dwork) w_state_next = ST_PULSE;
                    end
                    ST_PULSE: begin
                        w_miss_inc[gi] = w_edge;
                        if (r_wcnt >= r_wwork)
                            w_state_next = r_ctrl[gi][2] ? ST_ARMED : ST_DONE;
                    end
                    ST_DONE:
                        if (w_rearm) w_state_next = ST_ARMED;
                    default:
                        w_state_next = ST_IDLE;
                endcase
            end
        end

        // Working copies latched at the trigger edge, and the delay/width counters
        always_ff @(posedge timerclk or negedge reset_n) begin
            if (!reset_n) begin
                r_dcnt  <= '0;
                r_wcnt  <= '0;
                r_dwork <= '0;
                r_wwork <= CNT_ONE;
            end else if (w_load) begin
                r_dwork <= r_delay[gi];
                r_wwork <= (r_width[gi] == '0) ? CNT_ONE : r_width[gi];
                r_dcnt  <= CNT_ONE;
                r_wcnt  <= CNT_ONE;
            end else if (r_state == ST_DELAY) begin
                r_dcnt <= r_dcnt + CNT_ONE;
            end else if (r_state == ST_PULSE) begin
                r_wcnt <= r_wcnt + CNT_ONE;
            end
        end
    end

    // Registered outputs; trigger_any shares the same pulse terms so it lines up
    always_ff @(posedge timerclk or negedge reset_n) begin
        if (!reset_n) begin
            r_trigger     <= '0;
            r_trigger_any <= 1'b0;
        end else begin
            r_trigger     <= w_pulse;
            r_trigger_any <= |w_pulse;
        end
    end

    assign trigger     = r_trigger;
    assign trigger_any = r_trigger_any;

    // Combinational read mux; anything out of range reads as zero
    always_comb begin
        reg_if.reg_data_out = 8'h00;
        if (reg_if.reg_read) begin
            if (w_cmd_chsel) begin
                if (w_bc0) reg_if.reg_data_out = r_ch_sel;
            end else if (w_ch_valid) begin
                if (w_cmd_delay && w_bc_cnt)
                    reg_if.reg_data_out = r_delay[w_ch][{w_byte_idx, 3'b000} +: 8];
                else if (w_cmd_width && w_bc_cnt)
                    reg_if.reg_data_out = r_width[w_ch][{w_byte_idx, 3'b000} +: 8];
                else if (w_cmd_ctrl && w_bc0)
                    reg_if.reg_data_out = {5'b00000, r_ctrl[w_ch]};
                else if (w_cmd_status && w_bc0)
                    reg_if.reg_data_out = {5'b00000, w_status[w_ch]};
                else if (w_cmd_status && w_bc1)
                    reg_if.reg_data_out = r_missed[w_ch];
            end
        end
    end
endmodule

// File: tb/tb_delay_pulse_multi.sv
// Directed bench for delay_pulse_multi: register access, edge-to-pulse timing
// per channel, missed-trigger counting, out-of-range accesses and reset.
module tb_delay_pulse_multi;
    localparam int         NUM_CH   = 4;
    localparam logic [7:0] C_CHSEL  = 8'h20;
    localparam logic [7:0] C_DELAY  = 8'h21;
    localparam logic [7:0] C_WIDTH  = 8'h22;
    localparam logic [7:0] C_CTRL   = 8'h23;
    localparam logic [7:0] C_STATUS = 8'h24;

    logic              timerclk;
    logic              reset_n;
    logic [NUM_CH-1:0] trigger_in;
    logic [NUM_CH-1:0] trigger;
    logic              trigger_any;

    int n_checks = 0;
    int n_errs   = 0;

    delay_pulse_multi_if bus ();

    delay_pulse_multi #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(32), .CMD_BASE(8'h20), .SYNC_STAGES(2)
    ) dut (
        .timerclk   (timerclk),
        .reset_n    (reset_n),
        .trigger_in (trigger_in),
        .reg_if     (bus),
        .trigger    (trigger),
        .trigger_any(trigger_any)
    );

    initial timerclk = 1'b0;
    always #5 timerclk = ~timerclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("check %s: got=%0h ok", tag, got);
        end
    endtask

    // Single-byte write; entered on a falling edge, the write lands on the next rising edge
    task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] d);
        bus.reg_cmd       = cmd;
        bus.reg_bytecount = bc;
        bus.reg_data_in   = d;
        bus.reg_write     = 1'b1;
        @(negedge timerclk);
        bus.reg_write     = 1'b0;
    endtask

    task automatic wr_cnt(input logic [7:0] cmd, input logic [31:0] v);
        for (int b = 0; b < 4; b++) wr(cmd, 16'(b), v[8*b +: 8]);
    endtask

    task automatic rd(input logic [7:0] cmd, input logic [15:0] bc, output logic [7:0] d);
        bus.reg_cmd       = cmd;
        bus.reg_bytecount = bc;
        bus.reg_read      = 1'b1;
        #1;
        d = bus.reg_data_out;
        bus.reg_read      = 1'b0;
        @(negedge timerclk);
    endtask

    // Bit m of the masks = output level just after rising edge k+m (k = next edge)
    task automatic capture(input int ch, input int ncyc, output logic [127:0] m, output logic [127:0] ma);
        m  = '0;
        ma = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge timerclk);
            m[i]  = trigger[ch];
            ma[i] = trigger_any;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   d;
        logic [127:0] m, ma;

        reset_n           = 1'b0;
        trigger_in        = '0;
        bus.reg_cmd       = 8'h00;
        bus.reg_bytecount = 16'h0000;
        bus.reg_data_in   = 8'h00;
        bus.reg_read      = 1'b0;
        bus.reg_write     = 1'b0;
        repeat (3) @(negedge timerclk);
        check_eq("rst_trigger", {trigger_any, trigger}, 0);
        reset_n = 1'b1;
        @(negedge timerclk);

        // Reset values
        rd(C_CHSEL, 0, d);  check_eq("rst_chsel", d, 8'h00);
        rd(C_DELAY, 0, d);  check_eq("rst_delay", d, 8'h00);
        rd(C_WIDTH, 0, d);  check_eq("rst_width", d, 8'h01);
        rd(C_CTRL, 0, d);   check_eq("rst_ctrl", d, 8'h00);
        rd(C_STATUS, 0, d); check_eq("rst_status", d, 8'h00);

        // 1: ch0 rising edge, D=5 W=3 -> high at k+8..k+10
        wr_cnt(C_DELAY, 5);
        wr_cnt(C_WIDTH, 3);
        wr(C_CTRL, 0, 8'h01);
        repeat (2) @(negedge timerclk);
        rd(C_STATUS, 0, d); check_eq("t1_armed", d, 8'h01);
        rd(C_DELAY, 0, d);  check_eq("t1_delay_rb", d, 8'h05);
        trigger_in[0] = 1'b1;
        capture(0, 20, m, ma);
        check_eq("t1_pulse", m, 128'h700);
        check_eq("t1_any", ma, 128'h700);
        rd(C_STATUS, 0, d); check_eq("t1_done", d, 8'h04);
        trigger_in[0] = 1'b0;

        // 2: ch1 falling edge, auto-rearm, D=0 W=1 -> pulse 3 cycles after each edge
        trigger_in[1] = 1'b1;
        wr(C_CHSEL, 0, 8'h01);
        wr_cnt(C_DELAY, 0);
        wr_cnt(C_WIDTH, 1);
        wr(C_CTRL, 0, 8'h07);
        repeat (3) @(negedge timerclk);
        for (int n = 0; n < 3; n++) begin
            trigger_in[1] = 1'b0;
            capture(1, 6, m, ma);
            check_eq($sformatf("t2_pulse%0d", n), m, 128'h8);
            trigger_in[1] = 1'b1;
            repeat (14) @(negedge timerclk);
        end
        rd(C_STATUS, 1, d); check_eq("t2_missed", d, 8'h00);
        rd(C_STATUS, 0, d); check_eq("t2_rearmed", d, 8'h01);
        rd(C_CTRL, 0, d);   check_eq("t2_ctrl_rb", d, 8'h07);

        // 3: ch2 D=100, second edge during DELAY is missed
        wr(C_CHSEL, 0, 8'h02);
        wr_cnt(C_DELAY, 100);
        wr(C_CTRL, 0, 8'h01);
        repeat (2) @(negedge timerclk);
        fork
            begin
                trigger_in[2] = 1'b1;
                repeat (3) @(negedge timerclk);
                trigger_in[2] = 1'b0;
                repeat (7) @(negedge timerclk);
                trigger_in[2] = 1'b1;
            end
            capture(2, 110, m, ma);
        join
        check_eq("t3_pulse", m, 128'd1 << 103);
        check_eq("t3_any", ma, 128'd1 << 103);
        rd(C_STATUS, 1, d); check_eq("t3_missed", d, 8'h01);
        wr(C_STATUS, 0, 8'h00);
        rd(C_STATUS, 1, d); check_eq("t3_missed_clr", d, 8'h00);
        trigger_in[2] = 1'b0;

        // 4: ch3 DELAY rewritten while busy only affects the next trigger
        wr(C_CHSEL, 0, 8'h03);
        wr_cnt(C_DELAY, 50);
        wr(C_CTRL, 0, 8'h05);
        repeat (2) @(negedge timerclk);
        fork
            begin
                trigger_in[3] = 1'b1;
                repeat (5) @(negedge timerclk);
                wr_cnt(C_DELAY, 7);
            end
            capture(3, 60, m, ma);
        join
        check_eq("t4_pulse_old", m, 128'd1 << 53);
        trigger_in[3] = 1'b0;
        repeat (3) @(negedge timerclk);
        trigger_in[3] = 1'b1;
        capture(3, 15, m, ma);
        check_eq("t4_pulse_new", m, 128'h400);
        rd(C_DELAY, 0, d); check_eq("t4_delay_rb", d, 8'h07);
        trigger_in[3] = 1'b0;

        // 5: out-of-range channel, bytecount, command, and read strobe low
        wr(C_CHSEL, 0, 8'h04);
        rd(C_CHSEL, 0, d); check_eq("t5_chsel_rb", d, 8'h04);
        bus.reg_cmd = C_CHSEL; bus.reg_bytecount = 0; bus.reg_read = 1'b0;
        #1;
        check_eq("t5_noread", bus.reg_data_out, 8'h00);
        @(negedge timerclk);
        wr_cnt(C_DELAY, 32'hAABBCCDD);
        rd(C_DELAY, 0, d); check_eq("t5_badch_delay", d, 8'h00);
        rd(C_CTRL, 0, d);  check_eq("t5_badch_ctrl", d, 8'h00);
        wr(C_CHSEL, 0, 8'h03);
        rd(C_DELAY, 0, d); check_eq("t5_ch3_kept", d, 8'h07);
        rd(C_DELAY, 3, d); check_eq("t5_ch3_b3", d, 8'h00);
        wr(C_CHSEL, 0, 8'h00);
        rd(C_DELAY, 0, d); check_eq("t5_ch0_kept", d, 8'h05);
        wr(C_DELAY, 4, 8'hEE);
        rd(C_DELAY, 4, d); check_eq("t5_bc4_read", d, 8'h00);
        rd(C_DELAY, 0, d); check_eq("t5_bc4_b0", d, 8'h05);
        rd(C_DELAY, 1, d); check_eq("t5_bc4_b1", d, 8'h00);
        rd(8'h25, 0, d);   check_eq("t5_unk_cmd", d, 8'h00);
        rd(C_STATUS, 2, d); check_eq("t5_status_bc2", d, 8'h00);

        // 6: async reset during PULSE, then sw_trigger with D=2 W=2
        wr(C_CTRL, 0, 8'h01);
        repeat (2) @(negedge timerclk);
        trigger_in[0] = 1'b1;
        repeat (9) @(negedge timerclk);
        check_eq("t6_in_pulse", trigger[0], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_drop", {trigger_any, trigger}, 0);
        trigger_in = '0;
        repeat (2) @(negedge timerclk);
        reset_n = 1'b1;
        @(negedge timerclk);
        rd(C_CHSEL, 0, d);  check_eq("t6_chsel", d, 8'h00);
        rd(C_DELAY, 0, d);  check_eq("t6_delay", d, 8'h00);
        rd(C_WIDTH, 0, d);  check_eq("t6_width", d, 8'h01);
        rd(C_CTRL, 0, d);   check_eq("t6_ctrl", d, 8'h00);
        rd(C_STATUS, 0, d); check_eq("t6_status", d, 8'h00);
        wr_cnt(C_DELAY, 2);
        wr_cnt(C_WIDTH, 2);
        wr(C_CTRL, 0, 8'h01);
        repeat (2) @(negedge timerclk);
        fork
            wr(C_CTRL, 0, 8'h09);
            capture(0, 8, m, ma);
        join
        check_eq("t6_sw_pulse", m, 128'h18);
        check_eq("t6_sw_any", ma, 128'h18);
        rd(C_CTRL, 0, d); check_eq("t6_ctrl_sw_rd0", d, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
